// File: rtl/store_unit_pkg.sv
// Shared types, size encodings and the pmem_write memory-model hook for store_unit.
// The in-package memory model records each write for observation.
package store_unit_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    COMMIT = 2'd2
  } drain_state_e;

  typedef struct packed {
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } store_entry_t;

  // Low address bits that must be zero for a store of the given size.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      SZ_D:    m = 3'b111;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  // Byte-enable pattern of the given size before it is shifted to its lane.
  function automatic logic [7:0] size_bytemask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      SZ_D:    m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // Memory model: remembers the last write and counts all of them.
  longint unsigned pmem_wr_count = 64'd0;
  longint unsigned pmem_wr_addr  = 64'd0;
  longint unsigned pmem_wr_data  = 64'd0;
  byte unsigned    pmem_wr_mask  = 8'd0;

  function automatic void pmem_write(input longint unsigned waddr,
                                     input longint unsigned wdata,
                                     input byte unsigned wmask);
    pmem_wr_addr  = waddr;
    pmem_wr_data  = wdata;
    pmem_wr_mask  = wmask;
    pmem_wr_count = pmem_wr_count + 64'd1;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Circular store buffer; with STORE_FWD_EN it also exposes per-entry valid/address for hazard checks.
module store_fifo
  import store_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  store_entry_t             push_entry,
  input  logic                     pop,
  output store_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef STORE_FWD_EN
  ,
  output logic [DEPTH-1:0]         ent_valid,
  output logic [DEPTH-1:0][63:0]   ent_waddr
`endif
);

  localparam int PW = $clog2(DEPTH);

  store_entry_t    mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW:0]     count_r;
  logic            do_push_s;
  logic            do_pop_s;

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign full      = (count_r == (PW+1)'(DEPTH));
  assign empty     = (count_r == (PW+1)'(0));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= (PW+1)'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; stale contents are never read because occupancy gates them.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_entry;
  end

`ifdef STORE_FWD_EN
  // An entry is live when its distance from the read pointer is below occupancy.
  always_comb begin
    ent_valid = '0;
    ent_waddr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, PW'(i) - rd_ptr_r} < count_r);
      ent_waddr[i] = mem_r[i].waddr;
    end
  end
`endif

endmodule

// File: rtl/store_unit.sv
// Store unit: aligns stores into 64-bit words, buffers them and retires each through pmem_write.
// Macro STORE_FWD_EN adds the ld_addr/ld_stall load-hazard probe.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WR_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [63:0] st_addr,
  input  logic [63:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_misalign,
`ifdef STORE_FWD_EN
  input  logic [63:0] ld_addr,
  output logic        ld_stall,
`endif
  output logic        idle
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int WCW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [WCW-1:0] WCNT_INIT = (WR_LAT > 0) ? WCW'(WR_LAT - 1) : WCW'(0);

  drain_state_e   state_r;
  drain_state_e   state_nxt_s;
  logic [WCW-1:0] wcnt_r;
  logic [WCW-1:0] wcnt_nxt_s;
  logic           st_misalign_r;
  logic           accept_s;
  logic           misalign_s;
  logic           push_s;
  logic           pop_s;
  logic           full_s;
  logic           empty_s;
  logic [CW-1:0]  count_s;
  logic [2:0]     off_s;
  store_entry_t   new_entry_s;
  store_entry_t   head_s;

  assign st_ready   = !full_s;
  assign accept_s   = st_valid && st_ready;
  assign misalign_s = ((st_addr[2:0] & align_mask(st_size)) != 3'b000);
  assign push_s     = accept_s && !misalign_s;
  assign off_s      = st_addr[2:0];

  // Word address, lane-shifted data and byte enables of the incoming store.
  always_comb begin
    new_entry_s.waddr = {st_addr[63:3], 3'b000};
    new_entry_s.wdata = st_data << {off_s, 3'b000};
    new_entry_s.wmask = size_bytemask(st_size) << off_s;
  end

`ifdef STORE_FWD_EN
  logic [DEPTH-1:0]       ent_valid_s;
  logic [DEPTH-1:0][63:0] ent_waddr_s;
  logic                   unused_ld_low_s;

  assign unused_ld_low_s = ^ld_addr[2:0];
`endif

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .push_entry (new_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .full       (full_s),
    .empty      (empty_s),
`ifdef STORE_FWD_EN
    .ent_valid  (ent_valid_s),
    .ent_waddr  (ent_waddr_s),
`endif
    .count      (count_s)
  );

  // Drain FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      wcnt_r  <= WCW'(0);
    end else begin
      state_r <= state_nxt_s;
      wcnt_r  <= wcnt_nxt_s;
    end
  end

  // Next state; a push landing during COMMIT keeps the drain going without an IDLE bubble.
  always_comb begin
    state_nxt_s = state_r;
    wcnt_nxt_s  = wcnt_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          if (WR_LAT == 0) begin
            state_nxt_s = COMMIT;
          end else begin
            state_nxt_s = WAIT;
            wcnt_nxt_s  = WCNT_INIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (wcnt_r == WCW'(0)) begin
          state_nxt_s = COMMIT;
        end else begin
          wcnt_nxt_s = wcnt_r - WCW'(1);
        end
      end
      COMMIT: begin
        if ((count_s > CW'(1)) || push_s) begin
          if (WR_LAT == 0) begin
            state_nxt_s = COMMIT;
          end else begin
            state_nxt_s = WAIT;
            wcnt_nxt_s  = WCNT_INIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        wcnt_nxt_s  = WCW'(0);
      end
    endcase
  end

  // FSM-derived outputs.
  always_comb begin
    pop_s = (state_r == COMMIT);
    idle  = empty_s && (state_r == IDLE);
  end

  // One memory write per COMMIT cycle, issued on its closing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_misalign_r <= 1'b0;
    end else begin
      st_misalign_r <= accept_s && misalign_s;
      if (pop_s) pmem_write(head_s.waddr, head_s.wdata, head_s.wmask);
    end
  end

  assign st_misalign = st_misalign_r;

`ifdef STORE_FWD_EN
  // Any live entry in the load's 8-byte word blocks the load.
  always_comb begin
    ld_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid_s[i] && (ent_waddr_s[i][63:3] == ld_addr[63:3])) ld_stall = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: expected writes are queued at acceptance and checked as they retire.
module tb_store_unit;
  import store_unit_pkg::*;

  localparam int WR_LAT = 1;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  m;
    int          acc;
    bit          chk_lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [63:0] st_addr = 64'd0;
  logic [63:0] st_data = 64'd0;
  logic [1:0]  st_size = 2'd0;
  logic        st_misalign;
  logic        idle;
`ifdef STORE_FWD_EN
  logic [63:0] ld_addr = 64'd0;
  logic        ld_stall;
`endif

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   wr_seen = 0;
  longint unsigned last_cnt = 64'd0;
  exp_t sb[$];

  store_unit #(.DEPTH(4), .WR_LAT(WR_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_size     (st_size),
    .st_misalign (st_misalign),
`ifdef STORE_FWD_EN
    .ld_addr     (ld_addr),
    .ld_stall    (ld_stall),
`endif
    .idle        (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Retirement monitor: each new write is matched against the oldest expectation.
  always @(negedge clk) begin
    if (pmem_wr_count != last_cnt) begin
      last_cnt = pmem_wr_count;
      wr_seen++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h mask=%h", pmem_wr_addr, pmem_wr_data, pmem_wr_mask);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (pmem_wr_addr !== e.a || pmem_wr_data !== e.d || pmem_wr_mask !== e.m) begin
          bad++;
          $display("FAIL write_content got %h/%h/%h want %h/%h/%h",
                   pmem_wr_addr, pmem_wr_data, pmem_wr_mask, e.a, e.d, e.m);
        end
        if (e.chk_lat) begin
          total++;
          if (cyc - e.acc !== WR_LAT + 2) begin
            bad++;
            $display("FAIL write_latency got %0d edges want %0d", cyc - e.acc, WR_LAT + 2);
          end
        end
      end
    end
  end

  // Drive one store, wait for the handshake and queue the expected write if it should be enqueued.
  task automatic send(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz,
                      input bit exp_push, input logic [63:0] ea, input logic [63:0] ed,
                      input logic [7:0] em, input bit chk_lat);
    int waited = 0;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = sz;
    while (!st_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) begin
      total++; bad++;
      $display("FAIL handshake_timeout addr=%h", a);
      st_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      if (exp_push) sb.push_back('{ea, ed, em, cyc, chk_lat});
      st_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || !idle) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk); #1;
    total++;
    if (sb.size() != 0 || idle !== 1'b1) begin
      bad++;
      $display("FAIL %s_drain pending=%0d idle=%b want 0/1", name, sb.size(), idle);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (st_ready !== 1'b1 || idle !== 1'b1 || st_misalign !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs ready=%b idle=%b misalign=%b want 1/1/0", st_ready, idle, st_misalign);
    end
`ifdef STORE_FWD_EN
    total++;
    if (ld_stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_ld_stall got %b want 0", ld_stall);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_byte_store();
    send(64'h8000_0003, 64'h0000_0000_0000_00AB, SZ_B, 1'b1,
         64'h8000_0000, 64'h0000_0000_AB00_0000, 8'h08, 1'b1);
    total++;
    if (idle !== 1'b0) begin
      bad++;
      $display("FAIL byte_busy idle=%b want 0", idle);
    end
    wait_drain("byte");
  endtask

  task automatic test_word_store();
    send(64'h8000_0004, 64'h1122_3344_5566_7788, SZ_W, 1'b1,
         64'h8000_0000, 64'h5566_7788_0000_0000, 8'hF0, 1'b1);
    send(64'h8000_0106, 64'h0000_0000_0000_BEEF, SZ_H, 1'b1,
         64'h8000_0100, 64'hBEEF_0000_0000_0000, 8'hC0, 1'b0);
    wait_drain("word_half");
  endtask

  task automatic test_misalign();
    int w0 = wr_seen;
    send(64'h8000_0002, 64'h0000_0000_DEAD_BEEF, SZ_W, 1'b0, 64'd0, 64'd0, 8'd0, 1'b0);
    total++;
    if (st_misalign !== 1'b1) begin
      bad++;
      $display("FAIL misalign_pulse got %b want 1", st_misalign);
    end
    @(posedge clk); #1;
    total++;
    if (st_misalign !== 1'b0 || idle !== 1'b1) begin
      bad++;
      $display("FAIL misalign_clear misalign=%b idle=%b want 0/1", st_misalign, idle);
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (wr_seen !== w0) begin
      bad++;
      $display("FAIL misalign_no_write got %0d writes want 0", wr_seen - w0);
    end
    send(64'h8000_0008, 64'h0123_4567_89AB_CDEF, SZ_D, 1'b1,
         64'h8000_0008, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
    wait_drain("after_misalign");
  endtask

  task automatic test_back_to_back();
    bit saw_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [63:0] a;
      logic [63:0] d;
      a = 64'(i) * 64'd8;
      d = 64'hA5A5_0000_0000_0000 | 64'(i);
      send(a, d, SZ_D, 1'b1, a, d, 8'hFF, 1'b0);
      if (st_ready === 1'b0) saw_full = 1'b1;
    end
    total++;
    if (saw_full !== 1'b1) begin
      bad++;
      $display("FAIL fill_backpressure st_ready never low, want low once buffer full");
    end
    wait_drain("fill");
  endtask

  task automatic test_reset_mid_drain();
    int w0 = wr_seen;
    int n = 0;
    for (int i = 0; i < 3; i++) begin
      send(64'h4000 + 64'(i) * 64'd8, 64'hC0DE_0000 + 64'(i), SZ_D, 1'b1,
           64'h4000 + 64'(i) * 64'd8, 64'hC0DE_0000 + 64'(i), 8'hFF, 1'b0);
    end
    while (wr_seen == w0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (st_ready !== 1'b1 || idle !== 1'b1 || st_misalign !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs ready=%b idle=%b misalign=%b want 1/1/0", st_ready, idle, st_misalign);
    end
`ifdef STORE_FWD_EN
    total++;
    if (ld_stall !== 1'b0) begin
      bad++;
      $display("FAIL midreset_ld_stall got %b want 0", ld_stall);
    end
`endif
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (wr_seen - w0 !== 1) begin
      bad++;
      $display("FAIL midreset_write_count got %0d want 1", wr_seen - w0);
    end
  endtask

`ifdef STORE_FWD_EN
  task automatic test_store_fwd();
    longint unsigned c0;
    int n = 0;
    ld_addr  = 64'h8000_0014;
    st_valid = 1'b1; st_addr = 64'h8000_0010; st_data = 64'h77; st_size = SZ_D;
    #1;
    total++;
    if (ld_stall !== 1'b0) begin
      bad++;
      $display("FAIL fwd_same_cycle got %b want 0", ld_stall);
    end
    c0 = pmem_wr_count;
    send(64'h8000_0010, 64'h77, SZ_D, 1'b1, 64'h8000_0010, 64'h77, 8'hFF, 1'b0);
    while (pmem_wr_count == c0 && n < 20) begin
      total++;
      if (ld_stall !== 1'b1) begin
        bad++;
        $display("FAIL fwd_stall_pending got %b want 1", ld_stall);
      end
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (ld_stall !== 1'b0 || n >= 20) begin
      bad++;
      $display("FAIL fwd_stall_after_commit got %b want 0 (cycles=%0d)", ld_stall, n);
    end
    wait_drain("fwd1");
    ld_addr = 64'h8000_0018;
    send(64'h8000_0010, 64'h99, SZ_D, 1'b1, 64'h8000_0010, 64'h99, 8'hFF, 1'b0);
    total++;
    if (ld_stall !== 1'b0) begin
      bad++;
      $display("FAIL fwd_other_word got %b want 0", ld_stall);
    end
    wait_drain("fwd2");
  endtask
`endif

  initial begin
    test_reset();
    test_byte_store();
    test_word_store();
    test_misalign();
    test_back_to_back();
    test_reset_mid_drain();
`ifdef STORE_FWD_EN
    test_store_fwd();
`endif
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_unit.md
# store_unit

Write-side companion to the ALU's DPI load path: accepts store requests from the execute stage, aligns data into the 64-bit memory word, buffers them in a small FIFO, and retires each one to simulated physical memory through the DPI `pmem_write(waddr, wdata, wmask)` call. It sits between execute/writeback and the DPI memory model. It decouples store issue from memory latency and exposes an idle flag for fence/halt logic.

## Interface
Parameters:
- DEPTH, 4: store-buffer entries; power of two, ≥2.
- WR_LAT, 1: wait cycles before the head entry commits; 0 allowed.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; **asynchronous, active-low**.
- st_valid  in  1  store request valid.
- st_ready  out  1  buffer can accept; `!full`.
- st_addr  in  64  byte address.
- st_data  in  64  store data, LSB-justified.
- st_size  in  2  0=byte, 1=half, 2=word, 3=dword.
- st_misalign  out  1  one-cycle pulse when a misaligned request is dropped.
- ld_addr  in  64  load address probed for hazards; present only with STORE_FWD_EN.
- ld_stall  out  1  pending store overlaps `ld_addr`'s 8-byte word; present only with STORE_FWD_EN.
- idle  out  1  buffer empty and FSM in IDLE.

## Operation
- Handshake: a request is accepted when `st_valid && st_ready`.
- `st_ready` depends only on `full`. There is no same-cycle push-when-full, even if a pop occurs in that cycle.
- Alignment check: `addr` must be aligned to `1<<st_size` bytes.
  - A misaligned request is consumed (handshake completes) but is not enqueued.
  - `st_misalign` is 1 in the following cycle.
- Entry formation for an accepted aligned request:
  - `off = addr[2:0]`
  - `waddr = {addr[63:3],3'b0}`
  - `wdata = st_data << (off*8)`, truncated to 64 bits; data bits above the size are ignored.
  - `wmask[7:0] = ((1<<(1<<st_size))-1) << off`
- FIFO: DEPTH entries; read/write pointers of log2(DEPTH) bits, wrapping naturally; an occupancy counter of log2(DEPTH)+1 bits.
- Drain FSM (operates on the head entry):
  - IDLE: if the FIFO is not empty, go to WAIT (or COMMIT if WR_LAT=0) and load `wcnt=WR_LAT-1`.
  - WAIT: decrement `wcnt`; go to COMMIT when `wcnt==0`.
  - COMMIT: call `pmem_write` exactly once with the head entry, pop it, then go to WAIT/COMMIT if further entries remain, otherwise IDLE.
- Ordering: commits occur strictly in acceptance order. Each accepted aligned store produces exactly one `pmem_write`.
- Simultaneous push and pop: allowed when not full; occupancy stays unchanged.
- Reset mid-operation: all pending entries are discarded, no `pmem_write` is issued for them, and the FSM returns to IDLE.

## Timing
- Reset values:
  - `st_ready`=1
  - `st_misalign`=0
  - `ld_stall`=0
  - `idle`=1
  - pointers and counter 0
  - FSM IDLE
- Latency with an empty buffer: accept at edge N → FSM leaves IDLE at edge N+1 → `pmem_write` is called in the COMMIT cycle, WR_LAT+1 cycles after acceptance. With WR_LAT=0, this is the cycle after acceptance.
- Throughput: one commit per WR_LAT+1 cycles.
- `idle` is combinational from the registered state: 1 only when the FIFO is empty and the FSM is in IDLE.
- The `pmem_write` call is made from a clocked block on the COMMIT edge, never combinationally.

## Configuration
- STORE_FWD_EN defined:
  - The `ld_addr` port and `ld_stall` output exist.
  - `ld_stall` is combinational: 1 when any valid entry, including one in COMMIT, has `waddr == {ld_addr[63:3],3'b0}`.
  - A store accepted in the same cycle is not visible to `ld_stall` until the next cycle.
- STORE_FWD_EN undefined: no `ld_addr` port, no `ld_stall` output, and no comparators. The pipeline must instead wait for `idle` before loads that follow stores.

## Structure
- Shared package:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - FSM state enum (IDLE, WAIT, COMMIT)
  - entry struct {waddr[63:0], wdata[63:0], wmask[7:0]}
  - `pmem_write` DPI import declaration shared with the memory model
- Sub-module `store_fifo`: parameterised circular buffer with push/pop/full/empty/count, plus entry-valid and entry-address visibility for the hazard compare.
- The top level holds alignment, mask generation, the FSM, and the DPI call.

## Test plan
- Byte store: addr 0x80000003, data 0xAB, size 0 → one `pmem_write(0x80000000, 0xAB000000, 0x08)`, 2 cycles after accept (WR_LAT=1).
- Word store: addr 0x80000004, data 0x1122334455667788, size 2 → `pmem_write(0x80000000, 0x5566778800000000, 0xF0)`.
- Misaligned: addr 0x80000002, size 2 → `st_misalign`=1 for one cycle and no `pmem_write`; a following aligned store proceeds normally.
- Fill and backpressure, DEPTH=4: 5 back-to-back dword stores to 0x0, 0x8, 0x10, 0x18, 0x20 → `st_ready`=0 after the 4th; the 5th is accepted after the first commit; the 5 writes are issued in order and `idle` returns to 1.
- Reset mid-drain: 3 stores queued, `rst_n` pulsed low before the 2nd commit → exactly 1 `pmem_write` observed, and all outputs show reset values immediately.
- STORE_FWD_EN: store to 0x80000010 pending, `ld_addr`=0x80000014 → `ld_stall`=1 until that entry commits. With `ld_addr`=0x80000018 → `ld_stall`=0.
